// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler_if
// Purpose  : Signal bundle between the transmit scheduler and the UART core.
//            Carries the transmit handshake (tx_send/tx_data/busy) and the
//            receive flag service (rx_flag/rx_data/rx_flag_clr).
// Modports : master - scheduler side (drives tx_send, tx_data, rx_flag_clr)
//            slave  - UART side     (drives busy, rx_flag, rx_data)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              tx_send;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              rx_flag;
  logic [DATA_W-1:0] rx_data;
  logic              rx_flag_clr;

  modport master (
    output tx_send, tx_data, rx_flag_clr,
    input  busy, rx_flag, rx_data
  );

  modport slave (
    input  tx_send, tx_data, rx_flag_clr,
    output busy, rx_flag, rx_data
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Shares one UART transmitter between keyboard bytes and an echo
//            of received bytes. Each source has its own FIFO; a round-robin
//            arbiter feeds a send FSM that pulses tx_send once per byte and
//            follows the UART busy flag, aborting if busy never rises.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            uart (master)     - tx_send/tx_data/busy, rx_flag/rx_data/rx_flag_clr
//            kb_valid, kb_data - keyboard byte strobe and data
//            echo_en           - enable capture/echo of received bytes
//            clr_err           - clears sticky error flags
//            grant_src         - source of byte in flight (0 kb, 1 echo)
//            kb_full/echo_full - FIFO full indications
//            kb_ovf/echo_ovf   - sticky: byte dropped on full FIFO
//            tx_timeout        - sticky: busy never rose after a send
// Revision : 1.0 - initial release
// ============================================================================

// Small synchronous FIFO with occupancy count; read data is combinational
// from the head entry. A push while full is accepted only if a pop happens
// in the same cycle, otherwise the byte is dropped and 'drop' pulses.
module uart_tx_sched_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              drop
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_tx_scheduler #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 16,
  parameter int DATA_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_scheduler_if.master  uart,
  input  logic                 kb_valid,
  input  logic [DATA_W-1:0]    kb_data,
  input  logic                 echo_en,
  input  logic                 clr_err,
  output logic                 grant_src,
  output logic                 kb_full,
  output logic                 echo_full,
  output logic                 kb_ovf,
  output logic                 echo_ovf,
  output logic                 tx_timeout
);
  localparam int              CW      = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_END = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic [CW-1:0]     cnt;
  logic              rx_flag_q;
  logic              echo_rise;

  logic              kb_pop;
  logic              echo_pop;
  logic              kb_empty;
  logic              echo_empty;
  logic              kb_drop;
  logic              echo_drop;
  logic [DATA_W-1:0] kb_dout;
  logic [DATA_W-1:0] echo_dout;

  logic              load;
  logic              sel;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              timeout_set;

  // A new received byte is the rising edge of the level rx_flag.
  assign echo_rise = uart.rx_flag && !rx_flag_q && echo_en;

  uart_tx_sched_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_kb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (kb_valid),
    .pop   (kb_pop),
    .din   (kb_data),
    .dout  (kb_dout),
    .full  (kb_full),
    .empty (kb_empty),
    .drop  (kb_drop)
  );

  uart_tx_sched_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_echo_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (echo_rise),
    .pop   (echo_pop),
    .din   (uart.rx_data),
    .dout  (echo_dout),
    .full  (echo_full),
    .empty (echo_empty),
    .drop  (echo_drop)
  );

  // tx_send is decoded straight from the state register, so it is glitch
  // free and drops the instant reset asserts.
  assign uart.tx_send = (state == SEND);

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    sel         = 1'b0;
    kb_pop      = 1'b0;
    echo_pop    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        // A busy UART here belongs to another master; hold off.
        if (!uart.busy && (!kb_empty || !echo_empty)) begin
          load      = 1'b1;
          sel       = (!kb_empty && !echo_empty) ? !last_grant : kb_empty;
          kb_pop    = !sel;
          echo_pop  = sel;
          state_nxt = SEND;
        end
      end
      SEND: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart.busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_END) begin
          // This cycle's increment reaches BUSY_TIMEOUT: abandon the byte.
          timeout_set = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart.busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart.tx_data     <= '0;
      grant_src        <= 1'b0;
      last_grant       <= 1'b1;
      cnt              <= '0;
      rx_flag_q        <= 1'b0;
      uart.rx_flag_clr <= 1'b0;
      kb_ovf           <= 1'b0;
      echo_ovf         <= 1'b0;
      tx_timeout       <= 1'b0;
    end else begin
      if (load) begin
        uart.tx_data <= sel ? echo_dout : kb_dout;
        grant_src    <= sel;
        last_grant   <= sel;
      end

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;

      rx_flag_q        <= uart.rx_flag;
      // Cleared even when the echo FIFO dropped the byte.
      uart.rx_flag_clr <= echo_rise;

      // Set events take priority over clr_err.
      if (kb_drop)          kb_ovf     <= 1'b1;
      else if (clr_err)     kb_ovf     <= 1'b0;
      if (echo_drop)        echo_ovf   <= 1'b1;
      else if (clr_err)     echo_ovf   <= 1'b0;
      if (timeout_set)      tx_timeout <= 1'b1;
      else if (clr_err)     tx_timeout <= 1'b0;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Self-checking bench for uart_tx_scheduler. Expected bytes and
//            their source are queued when stimulus is driven and compared
//            when tx_send fires. A small UART model raises busy for 8 cycles
//            after each send unless told to stay idle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int BT     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              kb_valid = 1'b0;
  logic [DATA_W-1:0] kb_data  = '0;
  logic              echo_en  = 1'b0;
  logic              clr_err  = 1'b0;
  logic grant_src, kb_full, echo_full, kb_ovf, echo_ovf, tx_timeout;

  uart_tx_scheduler_if #(.DATA_W(DATA_W)) u_if ();

  uart_tx_scheduler #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart       (u_if),
    .kb_valid   (kb_valid),
    .kb_data    (kb_data),
    .echo_en    (echo_en),
    .clr_err    (clr_err),
    .grant_src  (grant_src),
    .kb_full    (kb_full),
    .echo_full  (echo_full),
    .kb_ovf     (kb_ovf),
    .echo_ovf   (echo_ovf),
    .tx_timeout (tx_timeout)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] data;
    logic       src;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // UART model
  logic force_busy = 1'b0;
  logic never_busy = 1'b0;
  int   busy_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)                                busy_cnt <= 0;
    else if (u_if.tx_send && !never_busy)   busy_cnt <= 8;
    else if (busy_cnt > 0)                  busy_cnt <= busy_cnt - 1;
  end
  assign u_if.busy = force_busy | (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!rst && u_if.tx_send === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_send", {31'b0, u_if.tx_send}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("tx_data", {24'b0, u_if.tx_data}, {24'b0, mon_e.data});
        check("grant_src", {31'b0, grant_src}, {31'b0, mon_e.src});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic kb_push(input logic [7:0] d, input bit expect_send);
    exp_t e;
    if (expect_send) begin
      e.data = d; e.src = 1'b0; sb.push_back(e);
    end
    @(posedge clk); #1 kb_valid = 1'b1; kb_data = d;
    @(posedge clk); #1 kb_valid = 1'b0;
  endtask

  // Raise rx_flag; clr must pulse exactly one cycle later when enabled.
  task automatic rx_byte(input logic [7:0] d, input bit en_expect);
    @(posedge clk); #1 u_if.rx_data = d; u_if.rx_flag = 1'b1;
    @(negedge clk); check("rx_clr_early", {31'b0, u_if.rx_flag_clr}, 32'd0);
    @(negedge clk); check("rx_clr_pulse", {31'b0, u_if.rx_flag_clr}, {31'b0, en_expect});
    @(posedge clk); #1 u_if.rx_flag = 1'b0;
    @(negedge clk); check("rx_clr_end", {31'b0, u_if.rx_flag_clr}, 32'd0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || u_if.busy) && n < 500) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    check(tag, sb.size(), 32'd0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    u_if.rx_flag = 1'b0;
    u_if.rx_data = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_tx_send",  {31'b0, u_if.tx_send}, 32'd0);
    check("rst_tx_data",  {24'b0, u_if.tx_data}, 32'd0);
    check("rst_grant",    {31'b0, grant_src}, 32'd0);
    check("rst_flags",    {26'b0, kb_full, echo_full, kb_ovf, echo_ovf, tx_timeout, u_if.rx_flag_clr}, 32'd0);

    // Single key latency: strobe in cycle N, tx_send in N+2
    kb_push(8'h31, 1'b1);
    @(negedge clk); check("lat_n1_send", {31'b0, u_if.tx_send}, 32'd0);
    @(negedge clk); check("lat_n2_send", {31'b0, u_if.tx_send}, 32'd1);
    @(negedge clk); check("lat_n3_send", {31'b0, u_if.tx_send}, 32'd0);
    drain("single_drain");

    // Round-robin: keyboard wins the first tie after reset
    do_reset();
    force_busy = 1'b1;
    echo_en = 1'b1;
    e.data = 8'h41; e.src = 1'b0; sb.push_back(e);
    e.data = 8'h61; e.src = 1'b1; sb.push_back(e);
    e.data = 8'h42; e.src = 1'b0; sb.push_back(e);
    e.data = 8'h62; e.src = 1'b1; sb.push_back(e);
    e.data = 8'h43; e.src = 1'b0; sb.push_back(e);
    kb_push(8'h41, 1'b0);
    rx_byte(8'h61, 1'b1);
    kb_push(8'h42, 1'b0);
    rx_byte(8'h62, 1'b1);
    kb_push(8'h43, 1'b0);
    @(negedge clk); check("rr_no_send_while_busy", sb.size(), 32'd5);
    force_busy = 1'b0;
    drain("rr_drain");

    // Echo capture enabled, then disabled
    e.data = 8'h5A; e.src = 1'b1; sb.push_back(e);
    rx_byte(8'h5A, 1'b1);
    drain("echo_drain");
    echo_en = 1'b0;
    rx_byte(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    check("echo_off_empty", {31'b0, echo_full}, 32'd0);
    echo_en = 1'b1;

    // Overflow on keyboard FIFO
    do_reset();
    force_busy = 1'b1;
    for (int i = 1; i <= 4; i++) kb_push(8'(i), 1'b1);
    @(negedge clk);
    check("ovf_full", {31'b0, kb_full}, 32'd1);
    check("ovf_before", {31'b0, kb_ovf}, 32'd0);
    kb_push(8'h05, 1'b0);
    @(negedge clk);
    check("ovf_set", {31'b0, kb_ovf}, 32'd1);
    force_busy = 1'b0;
    drain("ovf_drain");
    check("ovf_not_full", {31'b0, kb_full}, 32'd0);
    check("ovf_sticky", {31'b0, kb_ovf}, 32'd1);
    pulse_clr();
    check("ovf_cleared", {31'b0, kb_ovf}, 32'd0);

    // Timeout: busy never rises. WAIT_BUSY occupies the BT cycles after the
    // send cycle and the flag registers at the end of the last of them.
    never_busy = 1'b1;
    kb_push(8'h33, 1'b1);
    n = 0;
    while (u_if.tx_send !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    check("to_send_seen", {31'b0, u_if.tx_send}, 32'd1);
    for (int j = 1; j <= BT + 1; j++) begin
      @(negedge clk);
      if (j == BT)     check("to_flag_early", {31'b0, tx_timeout}, 32'd0);
      if (j == BT + 1) check("to_flag_set",   {31'b0, tx_timeout}, 32'd1);
    end
    never_busy = 1'b0;
    kb_push(8'h34, 1'b1);
    drain("to_next_byte");
    check("to_sticky", {31'b0, tx_timeout}, 32'd1);
    pulse_clr();
    check("to_cleared", {31'b0, tx_timeout}, 32'd0);

    // Reset in WAIT_DONE with bytes still queued
    force_busy = 1'b1;
    kb_push(8'h71, 1'b1);
    kb_push(8'h72, 1'b0);
    kb_push(8'h73, 1'b0);
    force_busy = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    check("mid_busy_high", {31'b0, u_if.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_send",  {31'b0, u_if.tx_send}, 32'd0);
    check("mid_rst_data",  {24'b0, u_if.tx_data}, 32'd0);
    check("mid_rst_grant", {31'b0, grant_src}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_idle_after", {31'b0, u_if.tx_send}, 32'd0);
    kb_push(8'h7E, 1'b1);
    drain("mid_new_byte");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
